btn_event: RTL and testbench

- Classifies one debounced push-button level into single-cycle events: press, release, short click, long press and auto-repeat.
- Sits directly downstream of the board debouncer and consumes its active-high level output.
- Shares the debouncer's 15 us timebase strobe.
- Feeds the CSR/interrupt logic and local UI FSMs, which need clean one-shot events rather than levels.

---
 rtl/btn_event.sv | 149 ++++++++++++++
 tb/tb_btn_event.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event.sv
// btn_event -- turns a debounced push-button level into one-shot events.
//
// Sits behind the board debouncer and shares its 15 us timebase strobe.
// A 20-bit counter, advanced only by tick_15us, measures hold time.
// A three-state FSM (IDLE / PRESSED / LONG) turns that measurement into
// press, release, short-click, long-press and auto-repeat pulses.
//
// Ports:
//   clk        system clock
//   arst       asynchronous reset, active-high
//   tick_15us  single-clk strobe, once per 15 us
//   btn        debounced button level, 1 = pressed
//   held       1 while the FSM is in PRESSED or LONG (registered)
//   press_p    1-clk pulse on press detect
//   release_p  1-clk pulse on release detect
//   short_p    1-clk pulse on a release before the long threshold
//   long_p     1-clk pulse when the long threshold is reached
//   repeat_p   1-clk pulse every REPEAT_TICKS while in LONG
//   state_dbg  current FSM state (0 IDLE, 1 PRESSED, 2 LONG) for debug
//
// Handshake: there is no valid/ready handshake. btn is a level, tick_15us is
// a free-running strobe, and every output pulse is a fire-and-forget 1-clk
// event with no back-pressure. A consumer must act on it in that cycle.
module btn_event #(
  parameter int   LONG_TICKS   = 66667,
  parameter int   REPEAT_TICKS = 13333,
  parameter logic REPEAT_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       tick_15us,
  input  logic       btn,
  output logic       held,
  output logic       press_p,
  output logic       release_p,
  output logic       short_p,
  output logic       long_p,
  output logic       repeat_p,
  output logic [1:0] state_dbg
);

  // Out-of-range parameters stop elaboration.
  if (LONG_TICKS < 2 || LONG_TICKS > 1048575) begin : g_bad_long
    $fatal(1, "btn_event: LONG_TICKS out of range 2..2^20-1");
  end
  if (REPEAT_TICKS < 1 || REPEAT_TICKS > 1048575) begin : g_bad_repeat
    $fatal(1, "btn_event: REPEAT_TICKS out of range 1..2^20-1");
  end

  localparam logic [19:0] LONG_T   = 20'(LONG_TICKS);
  localparam logic [19:0] REPEAT_T = 20'(REPEAT_TICKS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [19:0] cnt_inc;
  logic        btn_q;
  logic        press_d, release_d, short_d, long_d, repeat_d;

  assign cnt_inc   = cnt_q + 20'd1;
  assign state_dbg = state_q;

  // Next-state and event decode. A release is tested before the tick so that
  // a release landing on a threshold tick suppresses long_p / repeat_p.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Rising edge only; a button held through IDLE without an edge
        // cannot happen outside reset, and reset clears btn_q so a held
        // button still yields a fresh press afterwards.
        if (btn && !btn_q) begin
          press_d = 1'b1;
          cnt_d   = 20'd0;
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        if (!btn) begin
          release_d = 1'b1;
          short_d   = 1'b1;
          state_d   = IDLE;
        end else if (tick_15us) begin
          if (cnt_inc == LONG_T) begin
            long_d  = 1'b1;
            cnt_d   = 20'd0;
            state_d = LONG;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      LONG: begin
        if (!btn) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end else if (tick_15us) begin
          if (cnt_inc == REPEAT_T) begin
            repeat_d = REPEAT_EN;
            cnt_d    = 20'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 20'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= IDLE;
      cnt_q     <= 20'd0;
      btn_q     <= 1'b0;
      held      <= 1'b0;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      short_p   <= 1'b0;
      long_p    <= 1'b0;
      repeat_p  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_q     <= btn;
      // held tracks the state being entered so it moves with press_p/release_p.
      held      <= (state_d != IDLE);
      press_p   <= press_d;
      release_p <= release_d;
      short_p   <= short_d;
      long_p    <= long_d;
      repeat_p  <= repeat_d;
    end
  end

endmodule

// File: tb/tb_btn_event.sv
// Directed bench for btn_event. Three instances share clk/arst:
//   dut_a  LONG=4, REPEAT=2, repeat enabled
//   dut_b  LONG=4, REPEAT=2, repeat disabled (same stimulus as dut_a)
//   dut_f  full-length 66667/13333, own btn/tick
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge, so each sample shows the reaction to that cycle's inputs.
module tb_btn_event;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst = 1'b1;
  logic btn  = 1'b0;
  logic tick = 1'b0;
  logic btn_f  = 1'b0;
  logic tick_f = 1'b0;

  logic       held_a, press_a, rel_a, short_a, long_a, rep_a;
  logic [1:0] state_a;
  logic       held_b, press_b, rel_b, short_b, long_b, rep_b;
  logic [1:0] state_b;
  logic       held_f, press_f, rel_f, short_f, long_f, rep_f;
  logic [1:0] state_f;

  btn_event #(.LONG_TICKS(4), .REPEAT_TICKS(2), .REPEAT_EN(1'b1)) dut_a (
    .clk(clk), .arst(arst), .tick_15us(tick), .btn(btn),
    .held(held_a), .press_p(press_a), .release_p(rel_a), .short_p(short_a),
    .long_p(long_a), .repeat_p(rep_a), .state_dbg(state_a)
  );

  btn_event #(.LONG_TICKS(4), .REPEAT_TICKS(2), .REPEAT_EN(1'b0)) dut_b (
    .clk(clk), .arst(arst), .tick_15us(tick), .btn(btn),
    .held(held_b), .press_p(press_b), .release_p(rel_b), .short_p(short_b),
    .long_p(long_b), .repeat_p(rep_b), .state_dbg(state_b)
  );

  btn_event #(.LONG_TICKS(66667), .REPEAT_TICKS(13333), .REPEAT_EN(1'b1)) dut_f (
    .clk(clk), .arst(arst), .tick_15us(tick_f), .btn(btn_f),
    .held(held_f), .press_p(press_f), .release_p(rel_f), .short_p(short_f),
    .long_p(long_f), .repeat_p(rep_f), .state_dbg(state_f)
  );

  int checks   = 0;
  int failures = 0;

  // Event tallies for one run_hold sequence.
  int tick_cnt;
  int a_press, a_rel, a_short, a_long, a_long_tick, a_overlap, a_short_alone, a_held_bad;
  int b_press, b_rel, b_short, b_long, b_long_tick;
  int a_rep_ticks[$];
  int b_rep_ticks[$];

  // One clock cycle of stimulus for dut_a/dut_b, then tally the outputs.
  task automatic cyc(input logic b, input logic t);
    @(negedge clk);
    btn  = b;
    tick = t;
    @(posedge clk);
    #1;
    if (t) tick_cnt++;
    if (press_a) a_press++;
    if (rel_a) a_rel++;
    if (short_a) a_short++;
    if (long_a) begin a_long++; a_long_tick = tick_cnt; end
    if (rep_a) a_rep_ticks.push_back(tick_cnt);
    if (press_a && rel_a) a_overlap++;
    if (short_a && !rel_a) a_short_alone++;
    if (held_a !== b) a_held_bad++;
    if (press_b) b_press++;
    if (rel_b) b_rel++;
    if (short_b) b_short++;
    if (long_b) begin b_long++; b_long_tick = tick_cnt; end
    if (rep_b) b_rep_ticks.push_back(tick_cnt);
  endtask

  // Idle, hold btn for hold_clks cycles with a tick on every period-th clk
  // (never on the press cycle), release (optionally with a tick), idle.
  task automatic run_hold(input int hold_clks, input int period, input logic tie);
    tick_cnt = 0;
    a_press = 0; a_rel = 0; a_short = 0; a_long = 0; a_long_tick = -1;
    a_overlap = 0; a_short_alone = 0; a_held_bad = 0;
    b_press = 0; b_rel = 0; b_short = 0; b_long = 0; b_long_tick = -1;
    a_rep_ticks.delete();
    b_rep_ticks.delete();
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < hold_clks; i++) cyc(1'b1, (i % period) == period - 1);
    cyc(1'b0, tie);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({held_a, press_a, rel_a, short_a, long_a, rep_a, state_a} !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {held_a, press_a, rel_a, short_a, long_a, rep_a, state_a});
    end
    @(posedge clk); #1;
    checks++;
    if ({held_f, press_f, rel_f, short_f, long_f, rep_f, state_f} !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs_full got=%b exp=0", {held_f, press_f, rel_f, short_f, long_f, rep_f, state_f});
    end
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic test_short_click;
    run_hold(6, 3, 1'b0);  // ticks at hold clks 2 and 5 -> 2 ticks
    checks++; if (a_press !== 1) begin failures++; $display("FAIL short_press_cnt got=%0d exp=1", a_press); end
    checks++; if (a_rel !== 1) begin failures++; $display("FAIL short_release_cnt got=%0d exp=1", a_rel); end
    checks++; if (a_short !== 1) begin failures++; $display("FAIL short_short_cnt got=%0d exp=1", a_short); end
    checks++; if (a_short_alone !== 0) begin failures++; $display("FAIL short_with_release got=%0d exp=0", a_short_alone); end
    checks++; if (a_long !== 0) begin failures++; $display("FAIL short_long_cnt got=%0d exp=0", a_long); end
    checks++; if (a_held_bad !== 0) begin failures++; $display("FAIL short_held_bad got=%0d exp=0", a_held_bad); end
    checks++; if (a_overlap !== 0) begin failures++; $display("FAIL short_press_rel_overlap got=%0d exp=0", a_overlap); end
  endtask

  task automatic test_long_repeat;
    run_hold(30, 3, 1'b0);  // 10 ticks
    checks++; if (a_press !== 1) begin failures++; $display("FAIL long_press_cnt got=%0d exp=1", a_press); end
    checks++; if (a_long !== 1) begin failures++; $display("FAIL long_long_cnt got=%0d exp=1", a_long); end
    checks++; if (a_long_tick !== 4) begin failures++; $display("FAIL long_long_tick got=%0d exp=4", a_long_tick); end
    checks++;
    if (a_rep_ticks.size() !== 3) begin
      failures++; $display("FAIL long_repeat_cnt got=%0d exp=3", a_rep_ticks.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (a_rep_ticks[k] !== 6 + 2 * k) begin
          failures++; $display("FAIL long_repeat_tick%0d got=%0d exp=%0d", k, a_rep_ticks[k], 6 + 2 * k);
        end
      end
    end
    checks++; if (a_rel !== 1) begin failures++; $display("FAIL long_release_cnt got=%0d exp=1", a_rel); end
    checks++; if (a_short !== 0) begin failures++; $display("FAIL long_short_cnt got=%0d exp=0", a_short); end
    checks++; if (a_held_bad !== 0) begin failures++; $display("FAIL long_held_bad got=%0d exp=0", a_held_bad); end
  endtask

  task automatic test_no_repeat;
    run_hold(30, 3, 1'b0);
    checks++; if (b_press !== 1) begin failures++; $display("FAIL norep_press_cnt got=%0d exp=1", b_press); end
    checks++; if (b_long !== 1) begin failures++; $display("FAIL norep_long_cnt got=%0d exp=1", b_long); end
    checks++; if (b_long_tick !== 4) begin failures++; $display("FAIL norep_long_tick got=%0d exp=4", b_long_tick); end
    checks++; if (b_rep_ticks.size() !== 0) begin failures++; $display("FAIL norep_repeat_cnt got=%0d exp=0", b_rep_ticks.size()); end
    checks++; if (b_rel !== 1) begin failures++; $display("FAIL norep_release_cnt got=%0d exp=1", b_rel); end
    checks++; if (b_short !== 0) begin failures++; $display("FAIL norep_short_cnt got=%0d exp=0", b_short); end
  endtask

  task automatic test_tie;
    run_hold(9, 3, 1'b1);  // 3 ticks while held, 4th tick with the release
    checks++; if (a_rel !== 1) begin failures++; $display("FAIL tie_release_cnt got=%0d exp=1", a_rel); end
    checks++; if (a_short !== 1) begin failures++; $display("FAIL tie_short_cnt got=%0d exp=1", a_short); end
    checks++; if (a_long !== 0) begin failures++; $display("FAIL tie_long_cnt got=%0d exp=0", a_long); end
    checks++; if (a_rep_ticks.size() !== 0) begin failures++; $display("FAIL tie_repeat_cnt got=%0d exp=0", a_rep_ticks.size()); end
    checks++; if (state_a !== 2'd0) begin failures++; $display("FAIL tie_state got=%0d exp=0", state_a); end
    checks++; if (held_a !== 1'b0) begin failures++; $display("FAIL tie_held got=%b exp=0", held_a); end
  endtask

  task automatic test_reset_mid_press;
    run_hold(0, 3, 1'b0);  // clears tallies only
    cyc(1'b1, 1'b0);
    checks++; if (press_a !== 1'b1) begin failures++; $display("FAIL midrst_first_press got=%b exp=1", press_a); end
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    checks++; if (state_a !== 2'd1) begin failures++; $display("FAIL midrst_state_pressed got=%0d exp=1", state_a); end
    #2 arst = 1'b1;
    #1;
    checks++;
    if ({held_a, press_a, rel_a, short_a, long_a, rep_a, state_a} !== 8'd0) begin
      failures++;
      $display("FAIL midrst_async_clear got=%b exp=0", {held_a, press_a, rel_a, short_a, long_a, rep_a, state_a});
    end
    @(posedge clk); #1;
    checks++; if (rel_a !== 1'b0) begin failures++; $display("FAIL midrst_no_release got=%b exp=0", rel_a); end
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk); #1;
    checks++; if (press_a !== 1'b1) begin failures++; $display("FAIL midrst_repress got=%b exp=1", press_a); end
    checks++; if (held_a !== 1'b1) begin failures++; $display("FAIL midrst_held got=%b exp=1", held_a); end
    checks++; if (rel_a !== 1'b0) begin failures++; $display("FAIL midrst_repress_rel got=%b exp=0", rel_a); end
    cyc(1'b1, 1'b0);
    checks++; if (press_a !== 1'b0) begin failures++; $display("FAIL midrst_press_width got=%b exp=0", press_a); end
    cyc(1'b0, 1'b0);
    checks++; if (rel_a !== 1'b1) begin failures++; $display("FAIL midrst_final_release got=%b exp=1", rel_a); end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_full_length;
    int f_press, f_long, f_long_tick;
    int f_rep_ticks[$];
    f_press = 0; f_long = 0; f_long_tick = -1;
    @(negedge clk);
    btn_f  = 1'b1;
    tick_f = 1'b0;
    @(posedge clk); #1;
    if (press_f) f_press++;
    @(negedge clk);
    tick_f = 1'b1;
    for (int i = 1; i <= 80000; i++) begin
      @(posedge clk); #1;
      if (press_f) f_press++;
      if (long_f) begin f_long++; f_long_tick = i; end
      if (rep_f) f_rep_ticks.push_back(i);
    end
    @(negedge clk);
    btn_f  = 1'b0;
    tick_f = 1'b0;
    @(posedge clk); #1;
    checks++; if (f_press !== 1) begin failures++; $display("FAIL full_press_cnt got=%0d exp=1", f_press); end
    checks++; if (f_long !== 1) begin failures++; $display("FAIL full_long_cnt got=%0d exp=1", f_long); end
    checks++; if (f_long_tick !== 66667) begin failures++; $display("FAIL full_long_tick got=%0d exp=66667", f_long_tick); end
    checks++;
    if (f_rep_ticks.size() !== 1) begin
      failures++; $display("FAIL full_repeat_cnt got=%0d exp=1", f_rep_ticks.size());
    end else begin
      checks++;
      if (f_rep_ticks[0] !== 80000) begin failures++; $display("FAIL full_repeat_tick got=%0d exp=80000", f_rep_ticks[0]); end
    end
    checks++; if (rel_f !== 1'b1) begin failures++; $display("FAIL full_release got=%b exp=1", rel_f); end
    checks++; if (short_f !== 1'b0) begin failures++; $display("FAIL full_short got=%b exp=0", short_f); end
  endtask

  initial begin
    test_reset();
    test_short_click();
    test_long_repeat();
    test_no_repeat();
    test_tie();
    test_reset_mid_press();
    test_full_length();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
